// File: rtl/lfsr13_rng_pkg.sv
// Shared LFSR constants: maximal-length Fibonacci tap masks for widths 3..32
// and the default seed used when the instantiating block does not override it.
package lfsr_pkg;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_000F;

  // Bit i set means state[i] feeds the XOR; each entry gives a 2^w-1 period.
  function automatic logic [31:0] lfsr_tap_mask(input int w);
    logic [31:0] m;
    case (w)
      3:  m = 32'h0000_0006;
      4:  m = 32'h0000_000C;
      5:  m = 32'h0000_0014;
      6:  m = 32'h0000_0030;
      7:  m = 32'h0000_0060;
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_D008;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr13_rng_if.sv
// Published random word and its one-cycle strobe.
interface lfsr13_rng_if #(parameter int WIDTH = 13);
  logic [WIDTH-1:0] rnd;
  logic             rnd_valid;

  modport master (output rnd, rnd_valid);
  modport slave  (input  rnd, rnd_valid);
endinterface

// File: rtl/lfsr13_rng_lfsr_core.sv
// Fibonacci LFSR state register; shifts every clock, recovers from the
// all-zero lock-up state by reloading SEED.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 13,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(lfsr_tap_mask(WIDTH)),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             fb;

  always_comb begin
    fb      = ^(state_q & TAP_MASK);
    state_d = {state_q[WIDTH-2:0], fb};
    // Zero is a fixed point of the XOR feedback, only reachable by an upset.
    if (state_q == '0) state_d = SEED;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state = state_q;
  assign next  = state_d;

endmodule

// File: rtl/lfsr13_rng.sv
// Free-running LFSR noise source; publishes the post-shift state once every
// DECIMATE clocks so consecutive words share no shifted bits.
module lfsr13_rng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 13,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(lfsr_tap_mask(WIDTH)),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED),
  parameter int               DECIMATE = 13
) (
  input  logic             clock,
  input  logic             reset,
  lfsr13_rng_if.master     rng
);

  localparam logic [WIDTH-1:0] SEED_NZ  = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam int               CW       = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DECIMATE - 1);

  logic [WIDTH-1:0] core_state_unused;
  logic [WIDTH-1:0] next;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic             rnd_valid_q, rnd_valid_d;

  lfsr_core #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK),
    .SEED     (SEED_NZ)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .state (core_state_unused),
    .next  (next)
  );

  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    rnd_d       = rnd_q;
    rnd_valid_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d       = '0;
      rnd_d       = next;
      rnd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

  assign rng.rnd       = rnd_q;
  assign rng.rnd_valid = rnd_valid_q;

endmodule

// File: tb/tb_lfsr13_rng.sv
// Directed bench for lfsr13_rng with default parameters.
module tb_lfsr13_rng;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  lfsr13_rng_if #(.WIDTH(13)) rng ();

  lfsr13_rng dut (
    .clock (clock),
    .reset (reset),
    .rng   (rng)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [12:0] st;
    logic [12:0] rnd;
    logic        vld;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Edges (sampled at negedge) until rnd_valid is seen, bounded.
  task automatic edges_to_vld(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rng.rnd_valid && n < 100);
  endtask

  function automatic logic [12:0] step(input logic [12:0] s);
    return {s[11:0], ^(s & 13'h100D)};
  endfunction

  initial begin
    int          n, bad, seed_hits, zero_hits, rnd_zero;
    logic        published;
    logic [12:0] m;

    tbl[0]  = '{13'h001F, 13'h0000, 1'b0};
    tbl[1]  = '{13'h003F, 13'h0000, 1'b0};
    tbl[2]  = '{13'h007F, 13'h0000, 1'b0};
    tbl[3]  = '{13'h00FF, 13'h0000, 1'b0};
    tbl[4]  = '{13'h01FF, 13'h0000, 1'b0};
    tbl[5]  = '{13'h03FF, 13'h0000, 1'b0};
    tbl[6]  = '{13'h07FF, 13'h0000, 1'b0};
    tbl[7]  = '{13'h0FFF, 13'h0000, 1'b0};
    tbl[8]  = '{13'h1FFF, 13'h0000, 1'b0};
    tbl[9]  = '{13'h1FFE, 13'h0000, 1'b0};
    tbl[10] = '{13'h1FFD, 13'h0000, 1'b0};
    tbl[11] = '{13'h1FFA, 13'h0000, 1'b0};
    tbl[12] = '{13'h1FF4, 13'h1FF4, 1'b1};
    tbl[13] = '{13'h1FE8, 13'h1FF4, 1'b0};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_state", int'(dut.u_core.state_q), 13'h000F);
    check("reset_rnd", int'(rng.rnd), 0);
    check("reset_vld", int'(rng.rnd_valid), 0);

    // First 14 edges after release
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      check($sformatf("e%0d_state", i + 1), int'(dut.u_core.state_q), int'(tbl[i].st));
      check($sformatf("e%0d_rnd", i + 1), int'(rng.rnd), int'(tbl[i].rnd));
      check($sformatf("e%0d_vld", i + 1), int'(rng.rnd_valid), int'(tbl[i].vld));
    end
    // Pulse at edge 13 -> next at edge 26; edge 14 already consumed.
    edges_to_vld(n);
    check("second_pulse_gap", n + 1, 13);

    // Full period from reset
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m = 13'h000F; bad = 0; seed_hits = 0; zero_hits = 0; rnd_zero = 0; published = 1'b0;
    for (int e = 1; e <= 8191; e++) begin
      @(negedge clock);
      m = step(m);
      if (dut.u_core.state_q !== m) bad++;
      if (e < 8191 && dut.u_core.state_q == 13'h000F) seed_hits++;
      if (dut.u_core.state_q == 13'h0000) zero_hits++;
      if (rng.rnd_valid) published = 1'b1;
      if (published && rng.rnd == 13'h0000) rnd_zero++;
      if (rng.rnd_valid && rng.rnd !== m) bad++;
    end
    check("period_end_state", int'(dut.u_core.state_q), 13'h000F);
    check("period_model_mismatches", bad, 0);
    check("period_early_seed", seed_hits, 0);
    check("period_zero_state", zero_hits, 0);
    check("period_rnd_zero", rnd_zero, 0);

    // One-cycle reset mid-run at an odd counter phase
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_rnd", int'(rng.rnd), 0);
    check("midrst_vld", int'(rng.rnd_valid), 0);
    check("midrst_state", int'(dut.u_core.state_q), 13'h000F);
    reset = 1'b0;
    edges_to_vld(n);
    check("midrst_latency", n, 13);
    check("midrst_first_rnd", int'(rng.rnd), 13'h1FF4);

    // Lock-up recovery from a forced zero state
    repeat (3) @(negedge clock);
    force dut.u_core.state_q = 13'h0000;
    #1;
    release dut.u_core.state_q;
    #1;
    check("lockup_next", int'(dut.u_core.next), 13'h000F);
    @(negedge clock);
    check("lockup_reload", int'(dut.u_core.state_q), 13'h000F);
    @(negedge clock);
    check("lockup_continue", int'(dut.u_core.state_q), 13'h001F);

    // Reset held for 50 cycles
    reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (dut.u_core.state_q !== 13'h000F || rng.rnd !== 13'h0000 || rng.rnd_valid !== 1'b0) bad++;
    end
    check("long_reset_cycles_bad", bad, 0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
